minute_logic60: RTL and testbench

//  Minutes stage of the digital clock, sitting directly upstream of the hours (0-23) stage.

---
 rtl/minute_logic60.sv | 117 +++++++++++
 tb/tb_minute_logic60.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/minute_logic60.sv
// Minutes stage of the digital clock: 1 s prescaler, seconds 0-59, BCD minutes 00-59, 7-seg out.
// Latency: carry_out/hour_add registered (1 cycle); displays combinational from state registers.
// Backpressure: none; pulse-driven. Optional SECONDS_BLINK_EN drives display0 dp from sec[0].
module minute_logic60 #(
    parameter int DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add,
    input  logic       modify,
    input  logic       sel,
    output logic       carry_out,
    output logic       hour_add,
    output logic [7:0] display0,
    output logic [7:0] display1
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] prescaler;
    logic [5:0]    sec;
    logic [3:0]    min_u;
    logic [3:0]    min_t;

    logic tick;
    logic sec_wrap;
    logic min_max;
    logic set_inc;
    logic min_inc;
    logic dp0;

    // Set mode freezes the time base, so a tick can never coincide with a set-mode press.
    assign tick     = !modify && (prescaler == PRE_MAX);
    assign sec_wrap = tick && (sec == 6'd59);
    assign min_max  = (min_t == 4'd5) && (min_u == 4'd9);
    assign set_inc  = modify && add && !sel;
    assign min_inc  = sec_wrap || set_inc;

    always_ff @(posedge clk) begin
        if (rst || modify) begin
            prescaler <= '0;
        end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || modify) begin
            sec <= 6'd0;
        end else if (tick) begin
            sec <= sec_wrap ? 6'd0 : sec + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_u <= 4'd0;
            min_t <= 4'd0;
        end else if (min_inc) begin
            if (min_max || min_t > 4'd5) begin
                min_u <= 4'd0;
                min_t <= 4'd0;
            end else if (min_u >= 4'd9) begin
                min_u <= 4'd0;
                min_t <= min_t + 4'd1;
            end else begin
                min_u <= min_u + 4'd1;
            end
        end
    end

    // Set-mode wraps stay silent: only a run-mode seconds wrap carries into the hours stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_out <= 1'b0;
            hour_add  <= 1'b0;
        end else begin
            carry_out <= sec_wrap && min_max;
            hour_add  <= modify && add && sel;
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        s = 8'hff;
        case (d)
            4'd0:    s = 8'h02;
            4'd1:    s = 8'h9e;
            4'd2:    s = 8'h24;
            4'd3:    s = 8'h0c;
            4'd4:    s = 8'h98;
            4'd5:    s = 8'h48;
            4'd6:    s = 8'h40;
            4'd7:    s = 8'h1e;
            4'd8:    s = 8'h00;
            4'd9:    s = 8'h08;
            default: s = 8'hff;
        endcase
        return s;
    endfunction

`ifdef SECONDS_BLINK_EN
    assign dp0 = sec[0];
`else
    assign dp0 = 1'b0;
`endif

    always_comb begin
        display0 = seg7(min_u);
        display0 = {display0[7:1], dp0 | display0[0]};
        display1 = (min_t > 4'd5) ? 8'hff : (seg7(min_t) | 8'h01);
    end

endmodule

// File: tb/tb_minute_logic60.sv
// Directed bench for minute_logic60 with DIV=4.
module tb_minute_logic60;

    logic       clk = 1'b0;
    logic       rst;
    logic       add;
    logic       modify;
    logic       sel;
    logic       carry_out;
    logic       hour_add;
    logic [7:0] display0;
    logic [7:0] display1;

    int n_checks = 0;
    int n_fail   = 0;
    int carry_cnt;
    int hadd_cnt;

`ifdef SECONDS_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    minute_logic60 #(.DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .add      (add),
        .modify   (modify),
        .sel      (sel),
        .carry_out(carry_out),
        .hour_add (hour_add),
        .display0 (display0),
        .display1 (display1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each edge and tallying output pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (carry_out === 1'b1) carry_cnt++;
            if (hour_add === 1'b1) hadd_cnt++;
        end
    endtask

    task automatic pulse_add();
        add = 1'b1;
        step(1);
        add = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; add = 1'b0; modify = 1'b0; sel = 1'b0;
        carry_cnt = 0; hadd_cnt = 0;

        // 1. reset
        step(2);
        check("rst_d0", display0, 8'h02);
        check("rst_d1", display1, 8'h03);
        check("rst_carry", carry_out, 1'b0);
        check("rst_hadd", hour_add, 1'b0);
        rst = 1'b0;

        // 2. 60 ticks of run mode -> 01
        step(239);
        check("run_d0_before", display0, 8'h02 | 8'(BLINK));
        step(1);
        check("run_d0_01", display0, 8'h9e);
        check("run_d1_01", display1, 8'h03);
        check("run_no_carry", 8'(carry_cnt), 8'd0);

        // 3. set 01 -> 59, then run into the wrap
        modify = 1'b1; sel = 1'b0;
        for (int i = 0; i < 58; i++) pulse_add();
        check("set59_d0", display0, 8'h08);
        check("set59_d1", display1, 8'h49);
        check("set59_no_carry", 8'(carry_cnt), 8'd0);
        modify = 1'b0;
        step(239);
        check("wrap_d0_before", display0, 8'h08 | 8'(BLINK));
        check("wrap_carry_before", carry_out, 1'b0);
        step(1);
        check("wrap_carry", carry_out, 1'b1);
        check("wrap_d0", display0, 8'h02);
        check("wrap_d1", display1, 8'h03);
        step(1);
        check("wrap_carry_drop", carry_out, 1'b0);
        check("wrap_carry_cnt", 8'(carry_cnt), 8'd1);

        // 4. 60 set-mode presses -> silent wrap back to 00
        carry_cnt = 0;
        modify = 1'b1; sel = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pulse_add();
            if (i == 9) check("set10_d1", display1, 8'h9f);
            if (i == 58) check("set59b_d1", display1, 8'h49);
        end
        check("set60_d0", display0, 8'h02);
        check("set60_d1", display1, 8'h03);
        check("set60_no_carry", 8'(carry_cnt), 8'd0);

        // 5. hours add routing
        hadd_cnt = 0;
        sel = 1'b1; add = 1'b1;
        check("hadd_not_yet", hour_add, 1'b0);
        step(1);
        add = 1'b0;
        check("hadd_pulse", hour_add, 1'b1);
        check("hadd_min_same", display0, 8'h02);
        step(1);
        check("hadd_drop", hour_add, 1'b0);
        check("hadd_cnt", 8'(hadd_cnt), 8'd1);
        modify = 1'b0;
        pulse_add();
        sel = 1'b0;
        pulse_add();
        check("run_add_no_hadd", 8'(hadd_cnt), 8'd1);
        check("run_add_no_min", display0, 8'h02 | 8'(BLINK & dut.sec[0]));

        // 6. reset mid-count at 37, and mid hour_add pulse
        modify = 1'b1; sel = 1'b0;
        for (int i = 0; i < 37; i++) pulse_add();
        check("set37_d0", display0, 8'h1e);
        check("set37_d1", display1, 8'h0d);
        modify = 1'b0;
        step(10);
        check("mid_sec", 8'(dut.sec), 8'd2);
        rst = 1'b1;
        step(1);
        check("midrst_d0", display0, 8'h02);
        check("midrst_d1", display1, 8'h03);
        check("midrst_sec", 8'(dut.sec), 8'd0);
        check("midrst_pre", 8'(dut.prescaler), 8'd0);
        rst = 1'b0; modify = 1'b1; sel = 1'b1; add = 1'b1;
        step(1);
        check("pre_rst_hadd", hour_add, 1'b1);
        rst = 1'b1;
        step(1);
        check("rst_hadd_drop", hour_add, 1'b0);
        rst = 1'b0; add = 1'b0; modify = 1'b0; sel = 1'b0;

        // modify rising on a tick cycle discards the tick
        step(3);
        check("tick_cyc_pre", 8'(dut.prescaler), 8'd3);
        modify = 1'b1;
        step(1);
        check("tick_discard_sec", 8'(dut.sec), 8'd0);
        check("tick_discard_pre", 8'(dut.prescaler), 8'd0);
        modify = 1'b0;
        step(3);
        check("first_tick_wait", 8'(dut.sec), 8'd0);
        step(1);
        check("first_tick_sec", 8'(dut.sec), 8'd1);
        check("first_tick_d0", display0, 8'h02 | 8'(BLINK));
        step(4);
        check("second_tick_d0", display0, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
